// File: rtl/neural_acq_stream_frontend_pkg.sv
// Shared types and default widths for the neural acquisition frontend and
// the downstream packetiser.
package neural_acq_pkg;

   localparam int ACQ_DATA_WIDTH     = 16;
   localparam int ACQ_CH_ID_WIDTH    = 4;
   localparam int ACQ_NUM_CH         = 16;
   localparam int ACQ_FIFO_DEPTH     = 8;
   localparam int ACQ_TS_WIDTH       = 16;
   localparam int ACQ_DROP_CNT_WIDTH = 16;

   typedef struct packed {
      logic [ACQ_DATA_WIDTH-1:0]  data;
      logic [ACQ_CH_ID_WIDTH-1:0] channel;
      logic [ACQ_TS_WIDTH-1:0]    timestamp;
   } acq_sample_t;

endpackage

// File: rtl/neural_acq_stream_frontend_if.sv
// Valid/ready sample stream from the acquisition frontend to the packetiser.
interface acq_stream_if
   import neural_acq_pkg::*;
#(
   parameter int DATA_WIDTH  = ACQ_DATA_WIDTH,
   parameter int CH_ID_WIDTH = ACQ_CH_ID_WIDTH,
   parameter int TS_WIDTH    = ACQ_TS_WIDTH
) ();

   logic [DATA_WIDTH-1:0]  acq_data;
   logic [CH_ID_WIDTH-1:0] acq_channel;
   logic [TS_WIDTH-1:0]    acq_timestamp;
   logic                   acq_valid;
   logic                   acq_ready;

   modport master (
      output acq_data, acq_channel, acq_timestamp, acq_valid,
      input  acq_ready
   );

   modport slave (
      input  acq_data, acq_channel, acq_timestamp, acq_valid,
      output acq_ready
   );

endinterface

// File: rtl/neural_acq_stream_frontend_fifo.sv
// Generic single-clock first-word-fall-through FIFO with occupancy output.
module acq_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_en,
   input  logic [WIDTH-1:0]             wr_data,
   input  logic                         rd_en,
   output logic [WIDTH-1:0]             rd_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_rd;
   logic             do_wr;

   // Wrap bit distinguishes full from empty when the index bits match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign do_rd   = rd_en && !empty;
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_data = mem[rd_ptr[AW-1:0]];
   assign level   = LW'(wr_ptr - rd_ptr);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/neural_acq_stream_frontend.sv
// ADC acquisition frontend: channel qualification, timestamping, FIFO
// buffering onto a valid/ready stream, and overflow/bad-channel statistics.
module neural_acq_stream_frontend
   import neural_acq_pkg::*;
#(
   parameter int DATA_WIDTH     = ACQ_DATA_WIDTH,
   parameter int CH_ID_WIDTH    = ACQ_CH_ID_WIDTH,
   parameter int NUM_CH         = ACQ_NUM_CH,
   parameter int FIFO_DEPTH     = ACQ_FIFO_DEPTH,
   parameter int TS_WIDTH       = ACQ_TS_WIDTH,
   parameter int DROP_CNT_WIDTH = ACQ_DROP_CNT_WIDTH
) (
   input  logic                              sensor_clk,
   input  logic                              sensor_rst,
   input  logic [DATA_WIDTH-1:0]             adc_data_in,
   input  logic [CH_ID_WIDTH-1:0]            adc_channel_in,
   input  logic                              adc_valid_in,
   input  logic [NUM_CH-1:0]                 ch_enable_mask,
   input  logic                              clear_stats,
   acq_stream_if.master                      acq,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
   output logic [DROP_CNT_WIDTH-1:0]         drop_count,
   output logic                              overflow_sticky,
   output logic                              bad_ch_sticky
);

   localparam int MASK_W = 2**CH_ID_WIDTH;

   typedef struct packed {
      logic [DATA_WIDTH-1:0]  data;
      logic [CH_ID_WIDTH-1:0] channel;
      logic [TS_WIDTH-1:0]    timestamp;
   } sample_t;

   localparam int SAMPLE_W = $bits(sample_t);

   logic [TS_WIDTH-1:0] ts_q;
   logic [MASK_W-1:0]   mask_ext;
   logic                ch_in_range;
   logic                accept;
   logic                bad_ch;
   logic                fifo_full;
   logic                fifo_empty;
   logic                pop;
   logic                drop;
   logic                wr_en;
   sample_t             wr_sample;
   sample_t             rd_sample;

   // Mask is widened to the full channel-ID space so an out-of-range ID
   // never indexes past the real mask bits.
   assign mask_ext    = MASK_W'(ch_enable_mask);
   assign ch_in_range = (int'(adc_channel_in) < NUM_CH);
   assign accept      = adc_valid_in && ch_in_range && mask_ext[adc_channel_in];
   assign bad_ch      = adc_valid_in && !ch_in_range;
   assign pop         = !fifo_empty && acq.acq_ready;
   assign drop        = accept && fifo_full && !pop;
   assign wr_en       = accept && !drop;

   assign wr_sample.data      = adc_data_in;
   assign wr_sample.channel   = adc_channel_in;
   assign wr_sample.timestamp = ts_q;

   always_ff @(posedge sensor_clk) begin
      if (sensor_rst) begin
         ts_q <= '0;
      end else begin
         ts_q <= ts_q + TS_WIDTH'(1);
      end
   end

   // A clear coinciding with a drop or bad channel records that event.
   always_ff @(posedge sensor_clk) begin
      if (sensor_rst) begin
         drop_count      <= '0;
         overflow_sticky <= 1'b0;
         bad_ch_sticky   <= 1'b0;
      end else if (clear_stats) begin
         drop_count      <= drop ? DROP_CNT_WIDTH'(1) : '0;
         overflow_sticky <= drop;
         bad_ch_sticky   <= bad_ch;
      end else begin
         if (drop && (drop_count != '1)) begin
            drop_count <= drop_count + DROP_CNT_WIDTH'(1);
         end
         if (drop) begin
            overflow_sticky <= 1'b1;
         end
         if (bad_ch) begin
            bad_ch_sticky <= 1'b1;
         end
      end
   end

   acq_sync_fifo #(
      .WIDTH (SAMPLE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (sensor_clk),
      .rst     (sensor_rst),
      .wr_en   (wr_en),
      .wr_data (wr_sample),
      .rd_en   (pop),
      .rd_data (rd_sample),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   assign acq.acq_valid     = !fifo_empty;
   assign acq.acq_data      = rd_sample.data;
   assign acq.acq_channel   = rd_sample.channel;
   assign acq.acq_timestamp = rd_sample.timestamp;

endmodule
